// File: rtl/dbus_wb_bridge_if.sv
// CPU data-bus and Wishbone B.3 classic signals seen by dbus_wb_bridge.
// master: the bridge's view; slave: the CPU pipeline plus Wishbone slave side.
interface dbus_wb_bridge_if;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        bus_err_o;

  modport master (
    input  cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i, stall_i, flush_i,
    input  wb_dat_i, wb_ack_i,
    output cpu_data_o, stallreq_o, bus_err_o,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i, stall_i, flush_i,
    output wb_dat_i, wb_ack_i,
    input  cpu_data_o, stallreq_o, bus_err_o,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/dbus_wb_bridge.sv
// CPU data-bus to Wishbone B.3 classic master bridge, one access in flight.
// Stalls the pipeline until ack, flush or timeout; a timeout pulses bus_err_o and returns zero data.
module dbus_wb_bridge #(
  parameter int unsigned TIMEOUT = 256  // legal 2..65535
) (
  input  logic             clk,
  input  logic             rst,
  dbus_wb_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, WAIT_STALL = 2'd2} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_rd_buf;

  logic w_busy;
  logic w_expire;
  logic w_ack;
  logic w_flush_abort;
  logic w_timeout;
  logic w_drop;

  // Ack beats flush, flush beats timeout (an abandoned cycle is not an error).
  assign w_busy        = (r_state == BUSY);
  assign w_expire      = (r_cnt == CNT_LAST);
  assign w_ack         = w_busy && bus.wb_ack_i;
  assign w_flush_abort = w_busy && !bus.wb_ack_i && bus.flush_i;
  assign w_timeout     = w_busy && !bus.wb_ack_i && !bus.flush_i && w_expire;
  assign w_drop        = w_ack || w_flush_abort || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rd_buf      <= '0;
      bus.wb_cyc_o  <= 1'b0;
      bus.wb_stb_o  <= 1'b0;
      bus.wb_we_o   <= 1'b0;
      bus.wb_sel_o  <= '0;
      bus.wb_adr_o  <= '0;
      bus.wb_dat_o  <= '0;
      bus.bus_err_o <= 1'b0;
    end else begin
      bus.bus_err_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cpu_ce_i && !bus.flush_i) begin
            bus.wb_adr_o <= bus.cpu_addr_i;
            bus.wb_dat_o <= bus.cpu_data_i;
            bus.wb_we_o  <= bus.cpu_we_i;
            bus.wb_sel_o <= bus.cpu_sel_i;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            r_cnt        <= '0;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (w_drop) begin
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            bus.wb_we_o   <= 1'b0;
            bus.wb_sel_o  <= '0;
            bus.wb_adr_o  <= '0;
            bus.wb_dat_o  <= '0;
            bus.bus_err_o <= w_timeout;
            if (!w_flush_abort) begin
              r_rd_buf <= w_ack ? bus.wb_dat_i : 32'h0;
            end
            r_state <= (bus.stall_i && !w_flush_abort) ? WAIT_STALL : IDLE;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT_STALL: begin
          if (!bus.stall_i || bus.flush_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stallreq_o = 1'b0;
    bus.cpu_data_o = '0;
    if (!rst) begin
      case (r_state)
        IDLE: bus.stallreq_o = bus.cpu_ce_i && !bus.flush_i;
        BUSY: begin
          bus.stallreq_o = !(bus.wb_ack_i || w_expire) && !bus.flush_i;
          if (bus.wb_ack_i) begin
            bus.cpu_data_o = bus.wb_dat_i;
          end
        end
        WAIT_STALL: bus.cpu_data_o = r_rd_buf;
        default: bus.stallreq_o = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_wb_bridge.sv
// Randomised bench for dbus_wb_bridge: the bench plays both the CPU pipeline and the Wishbone slave,
// and predicts every cycle from the access outcome (ack / flush / timeout) and the stall length.
module tb_dbus_wb_bridge;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_err = 1'b0;

  dbus_wb_bridge_if bus ();

  dbus_wb_bridge #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [70:0] obs_bus;
  assign obs_bus = {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o};

  initial begin
    #500000;
    $display("FAIL watchdog: end of test not reached, required completion before time limit");
    $fatal(1);
  end

  // Cycles with no access in progress: ce is either low or cancelled by flush, so nothing may start.
  task automatic idle_gap(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.cpu_ce_i = 1'($urandom_range(0, 1));
      bus.flush_i  = bus.cpu_ce_i ? 1'b1 : 1'($urandom_range(0, 1));
      bus.stall_i  = 1'($urandom_range(0, 1));
      bus.wb_ack_i = 1'($urandom_range(0, 1));
      bus.wb_dat_i = $urandom;
      @(negedge clk);
      n_checks++;
      if (obs_bus !== '0 || bus.stallreq_o !== 1'b0 || bus.cpu_data_o !== '0 || bus.bus_err_o !== exp_err) begin
        n_errors++;
        $display("FAIL %s idle: bus=%h stallreq=%b data=%h err=%b, expected bus=0 stallreq=0 data=0 err=%b",
                 tag, obs_bus, bus.stallreq_o, bus.cpu_data_o, bus.bus_err_o, exp_err);
      end
      exp_err = 1'b0;
      @(posedge clk); #1;
    end
    bus.cpu_ce_i = 1'b0;
    bus.flush_i  = 1'b0;
  endtask

  // One access. lat: BUSY cycle that acks (0 = never); flush_at: BUSY cycle with flush (0 = none);
  // k: cycles the pipeline stays stalled after the access ends.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int lat, input int flush_at, input int k);
    logic [70:0] exp_bus;
    logic        ack_now, flush_now, end_now, exp_sr;
    logic [31:0] exp_d;
    int          outcome;
    exp_bus = {1'b1, 1'b1, we, sel, addr, wdata};
    bus.cpu_ce_i   = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_sel_i  = sel;
    bus.cpu_data_i = wdata;
    bus.flush_i    = 1'b0;
    bus.stall_i    = 1'($urandom_range(0, 1));
    bus.wb_ack_i   = 1'($urandom_range(0, 1));
    bus.wb_dat_i   = $urandom;
    @(negedge clk);
    n_checks++;
    if (obs_bus !== '0 || bus.stallreq_o !== 1'b1 || bus.cpu_data_o !== '0 || bus.bus_err_o !== exp_err) begin
      n_errors++;
      $display("FAIL %s request: bus=%h stallreq=%b data=%h err=%b, expected bus=0 stallreq=1 data=0 err=%b",
               tag, obs_bus, bus.stallreq_o, bus.cpu_data_o, bus.bus_err_o, exp_err);
    end
    @(posedge clk); #1;
    bus.cpu_we_i   = ~we;
    bus.cpu_addr_i = $urandom;
    bus.cpu_sel_i  = ~sel;
    bus.cpu_data_i = ~wdata;
    outcome = 0;
    for (int c = 1; outcome == 0; c++) begin
      ack_now   = (c == lat);
      flush_now = (c == flush_at);
      end_now   = ack_now || flush_now || (c == TMO);
      bus.cpu_ce_i = 1'($urandom_range(0, 1));
      bus.wb_ack_i = ack_now;
      bus.wb_dat_i = ack_now ? rdata : $urandom;
      bus.flush_i  = flush_now;
      bus.stall_i  = end_now ? (k > 0) : 1'($urandom_range(0, 1));
      exp_sr = !(ack_now || (c == TMO)) && !flush_now;
      exp_d  = ack_now ? rdata : 32'h0;
      @(negedge clk);
      n_checks++;
      if (obs_bus !== exp_bus || bus.stallreq_o !== exp_sr || bus.cpu_data_o !== exp_d || bus.bus_err_o !== 1'b0) begin
        n_errors++;
        $display("FAIL %s busy%0d: bus=%h stallreq=%b data=%h err=%b, expected bus=%h stallreq=%b data=%h err=0",
                 tag, c, obs_bus, bus.stallreq_o, bus.cpu_data_o, bus.bus_err_o, exp_bus, exp_sr, exp_d);
      end
      if (end_now) outcome = ack_now ? 1 : (flush_now ? 2 : 3);
      @(posedge clk); #1;
    end
    bus.cpu_ce_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    bus.flush_i  = 1'b0;
    exp_err = (outcome == 3);
    if (outcome != 2) begin
      for (int w = 1; w <= k; w++) begin
        exp_d = (outcome == 1) ? rdata : 32'h0;
        bus.wb_ack_i = 1'($urandom_range(0, 1));
        bus.wb_dat_i = $urandom;
        if (w < k) begin
          bus.stall_i = 1'b1;
          bus.flush_i = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          bus.stall_i = 1'b1;
          bus.flush_i = 1'b1;
        end else begin
          bus.stall_i = 1'b0;
          bus.flush_i = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (obs_bus !== '0 || bus.stallreq_o !== 1'b0 || bus.cpu_data_o !== exp_d || bus.bus_err_o !== exp_err) begin
          n_errors++;
          $display("FAIL %s wait%0d: bus=%h stallreq=%b data=%h err=%b, expected bus=0 stallreq=0 data=%h err=%b",
                   tag, w, obs_bus, bus.stallreq_o, bus.cpu_data_o, bus.bus_err_o, exp_d, exp_err);
        end
        exp_err = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.stall_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.wb_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h1000_0000;
    bus.cpu_sel_i = 4'hF; bus.cpu_data_i = 32'h1111_2222; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h3333_4444;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_bus !== '0 || bus.stallreq_o !== 1'b0 || bus.cpu_data_o !== '0 || bus.bus_err_o !== 1'b0) begin
        n_errors++;
        $display("FAIL reset%0d: bus=%h stallreq=%b data=%h err=%b, expected all 0",
                 i, obs_bus, bus.stallreq_o, bus.cpu_data_o, bus.bus_err_o);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.cpu_ce_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    exp_err = 1'b0;
    idle_gap("after_reset", 1);
  endtask

  task automatic test_load();
    do_txn("load", 1'b0, 32'h2000_0004, 4'b1111, $urandom, 32'hDEAD_BEEF, 3, 0, 0);
    idle_gap("load_end", 1);
  endtask

  task automatic test_sb_store();
    do_txn("sb_store", 1'b1, 32'h2000_0003, 4'b0001, 32'h5A5A_5A5A, $urandom, 2, 0, 0);
  endtask

  task automatic test_ack_stall();
    do_txn("ack_stall", 1'b0, $urandom, 4'b1111, $urandom, 32'h1234_5678, 1, 0, 2);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 1'b0, $urandom, 4'b1111, $urandom, 32'hCAFE_F00D, 0, 0, 0);
    idle_gap("timeout_err", 2);
    do_txn("timeout_stall", 1'b1, $urandom, 4'b0011, $urandom, 32'hCAFE_F00D, 6, 0, 2);
    do_txn("flush_at_timeout", 1'b0, $urandom, 4'b1100, $urandom, $urandom, 0, TMO, 0);
    idle_gap("flush_at_timeout_end", 1);
  endtask

  task automatic test_flush();
    do_txn("flush", 1'b0, $urandom, 4'b1111, $urandom, $urandom, 0, 2, 1);
    idle_gap("flush_end", 1);
    do_txn("ack_over_flush", 1'b0, $urandom, 4'b1111, $urandom, 32'h0BAD_F00D, 2, 2, 1);
  endtask

  task automatic test_reset_mid_busy();
    bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h4000_0010;
    bus.cpu_sel_i = 4'b0110; bus.cpu_data_i = 32'h7777_8888; bus.flush_i = 1'b0; bus.wb_ack_i = 1'b0;
    @(posedge clk); #1;
    bus.cpu_ce_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_bus !== {3'b111, 4'b0110, 32'h4000_0010, 32'h7777_8888}) begin
      n_errors++;
      $display("FAIL rst_mid_busy start: bus=%h, expected %h", obs_bus, {3'b111, 4'b0110, 32'h4000_0010, 32'h7777_8888});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cpu_ce_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stallreq_o !== 1'b0 || bus.cpu_data_o !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_busy held: stallreq=%b data=%h, expected stallreq=0 data=0", bus.stallreq_o, bus.cpu_data_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_ce_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_bus !== '0 || bus.stallreq_o !== 1'b0 || bus.cpu_data_o !== '0 || bus.bus_err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_busy after: bus=%h stallreq=%b data=%h err=%b, expected all 0",
               obs_bus, bus.stallreq_o, bus.cpu_data_o, bus.bus_err_o);
    end
    @(posedge clk); #1;
    exp_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_txn("back_to_back", 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)),
             $urandom, $urandom, $urandom_range(1, 2), 0, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int lat, fl, k;
      lat = $urandom_range(0, 6);
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      k   = $urandom_range(0, 3);
      do_txn("random", 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)),
             $urandom, $urandom, lat, fl, k);
      idle_gap("random_gap", $urandom_range(0, 2));
    end
  endtask

  initial begin
    bus.cpu_ce_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_sel_i = '0;
    bus.cpu_data_i = '0; bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0;
    test_reset();
    test_load();
    test_sb_store();
    test_ack_stall();
    test_timeout();
    test_flush();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    idle_gap("tail", 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
